// File: rtl/pipe_pkg.sv
// pipe_pkg -- shared types and constants for the elastic pipeline register.
//   occ_e        : occupancy / state encoding (value equals number of held entries)
//   STALL_CNT_W  : default width of the stall-cycle counter
package pipe_pkg;

  typedef enum logic [1:0] {
    OCC_EMPTY = 2'd0,
    OCC_ONE   = 2'd1,
    OCC_TWO   = 2'd2
  } occ_e;

  localparam int STALL_CNT_W = 16;

endpackage

// File: rtl/sat_cnt.sv
// sat_cnt -- saturating up-counter with synchronous clear.
//   clk   : clock, rising edge
//   nrst  : asynchronous active-low reset, forces count to zero
//   inc   : add one this cycle (ignored once the counter is all ones)
//   clr   : zero the counter next cycle, wins over inc
//   cnt   : current count
module sat_cnt #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         nrst,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] cnt
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (inc && (cnt_q != {W{1'b1}})) begin
      cnt_d = cnt_q + W'(1);
    end
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/elastic_ppreg.sv
// elastic_ppreg -- valid/ready pipeline register with optional skid entry.
//   SKID=1 : two entries (main + skid), in_ready comes straight from state flops
//   SKID=0 : one entry, in_ready = out_ready | empty (combinational)
// Ports:
//   clk, nrst            : clock (rising edge) and asynchronous active-low reset
//   flush                : synchronous kill of held and incoming entries
//   in_valid/in_ready/in_data    : upstream handshake and payload
//   out_valid/out_ready/out_data : downstream handshake and payload (out_data = main register)
//   occupancy            : number of entries held (0..2)
//   stat_clr             : synchronous clear of stall_cnt
//   stall_cnt            : saturating count of cycles with out_valid & ~out_ready
module elastic_ppreg
  import pipe_pkg::*;
#(
  parameter int DATA_W = 128,
  parameter int SKID   = 1,
  parameter int CNT_W  = STALL_CNT_W
) (
  input  logic              clk,
  input  logic              nrst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        occupancy,
  input  logic              stat_clr,
  output logic [CNT_W-1:0]  stall_cnt
);

  occ_e              state_q;
  occ_e              state_d;
  logic [DATA_W-1:0] main_q;
  logic [DATA_W-1:0] main_d;
  logic [DATA_W-1:0] skid_data;
  logic              up_xfer;
  logic              dn_xfer;

  assign up_xfer = in_valid & in_ready;
  assign dn_xfer = out_valid & out_ready;

  // ---------------- state register ----------------
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q <= OCC_EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  // ---------------- next-state logic ----------------
  always_comb begin
    state_d = state_q;
    if (flush) begin
      state_d = OCC_EMPTY;
    end else begin
      case (state_q)
        OCC_EMPTY: if (up_xfer) state_d = OCC_ONE;
        OCC_ONE: begin
          if (dn_xfer && !up_xfer) begin
            state_d = OCC_EMPTY;
          end else if (!dn_xfer && up_xfer && (SKID != 0)) begin
            // SKID guard keeps TWO structurally unreachable in stall mode
            state_d = OCC_TWO;
          end
        end
        OCC_TWO:   if (dn_xfer) state_d = OCC_ONE;
        default:   state_d = OCC_EMPTY;
      endcase
    end
  end

  // ---------------- outputs ----------------
  always_comb begin
    out_valid = (state_q != OCC_EMPTY);
    if (SKID != 0) begin
      // Registered ready: only depends on state, breaking the out_ready path
      in_ready = (state_q != OCC_TWO);
    end else begin
      in_ready = out_ready | (state_q == OCC_EMPTY);
    end
  end

  // ---------------- main register ----------------
  always_comb begin
    main_d = main_q;
    if (flush) begin
      main_d = '0;
    end else begin
      case (state_q)
        OCC_EMPTY: if (up_xfer) main_d = in_data;
        OCC_ONE:   if (up_xfer && dn_xfer) main_d = in_data;
        OCC_TWO:   if (dn_xfer) main_d = skid_data;
        default:   main_d = main_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      main_q <= '0;
    end else begin
      main_q <= main_d;
    end
  end

  // ---------------- skid register (SKID=1 only) ----------------
  generate
    if (SKID != 0) begin : g_skid
      logic [DATA_W-1:0] skid_q;
      logic [DATA_W-1:0] skid_d;

      // Skid captures only when main is held and cannot advance
      always_comb begin
        skid_d = skid_q;
        if (flush) begin
          skid_d = '0;
        end else if ((state_q == OCC_ONE) && up_xfer && !dn_xfer) begin
          skid_d = in_data;
        end
      end

      always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
          skid_q <= '0;
        end else begin
          skid_q <= skid_d;
        end
      end

      assign skid_data = skid_q;
    end else begin : g_no_skid
      assign skid_data = '0;
    end
  endgenerate

  assign out_data  = main_q;
  assign occupancy = state_q;

  // ---------------- stall statistics ----------------
  sat_cnt #(
    .W (CNT_W)
  ) u_stall_cnt (
    .clk  (clk),
    .nrst (nrst),
    .inc  (out_valid & ~out_ready),
    .clr  (stat_clr),
    .cnt  (stall_cnt)
  );

endmodule

// File: tb/tb_elastic_ppreg.sv
// Testbench: drives one stimulus stream into a SKID=1 and a SKID=0 instance
// (both CNT_W=4) and checks every cycle against a queue-level reference model.
module tb_elastic_ppreg;

  localparam int DW      = 32;
  localparam int CW      = 4;
  localparam int CNT_MAX = 15;

  logic          clk = 1'b0;
  logic          nrst;
  logic          flush;
  logic          in_valid;
  logic          out_ready;
  logic          stat_clr;
  logic [DW-1:0] in_data;

  logic          ir [2];
  logic          ov [2];
  logic [DW-1:0] od [2];
  logic [1:0]    oc [2];
  logic [CW-1:0] sc [2];

  int n_cmp = 0;
  int n_err = 0;

  // reference model: ordered list of held entries per instance
  logic [DW-1:0] mq    [2][2];
  int            mn    [2];
  logic [DW-1:0] mlast [2];
  int            mcnt  [2];
  int            skid_mode [2] = '{1, 0};

  always #5 clk = ~clk;

  elastic_ppreg #(.DATA_W(DW), .SKID(1), .CNT_W(CW)) u_skid (
    .clk(clk), .nrst(nrst), .flush(flush),
    .in_valid(in_valid), .in_ready(ir[0]), .in_data(in_data),
    .out_valid(ov[0]), .out_ready(out_ready), .out_data(od[0]),
    .occupancy(oc[0]), .stat_clr(stat_clr), .stall_cnt(sc[0])
  );

  elastic_ppreg #(.DATA_W(DW), .SKID(0), .CNT_W(CW)) u_stall (
    .clk(clk), .nrst(nrst), .flush(flush),
    .in_valid(in_valid), .in_ready(ir[1]), .in_data(in_data),
    .out_valid(ov[1]), .out_ready(out_ready), .out_data(od[1]),
    .occupancy(oc[1]), .stat_clr(stat_clr), .stall_cnt(sc[1])
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic bit exp_rdy(input int i);
    if (skid_mode[i] != 0) return (mn[i] < 2);
    return out_ready || (mn[i] == 0);
  endfunction

  function automatic logic [DW-1:0] exp_data(input int i);
    return (mn[i] > 0) ? mq[i][0] : mlast[i];
  endfunction

  task automatic model_clear();
    for (int i = 0; i < 2; i++) begin
      mn[i] = 0; mlast[i] = '0; mcnt[i] = 0;
    end
  endtask

  // Called at the falling edge with inputs already applied; returns at the next falling edge.
  task automatic cycle();
    bit up [2];
    bit dn [2];
    #1;
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("in_ready[%0d]", i),  ir[i], exp_rdy(i));
      chk($sformatf("out_valid[%0d]", i), ov[i], mn[i] > 0);
      chk($sformatf("out_data[%0d]", i),  od[i], exp_data(i));
      chk($sformatf("occupancy[%0d]", i), oc[i], mn[i]);
      chk($sformatf("stall_cnt[%0d]", i), sc[i], mcnt[i]);
      up[i] = in_valid && exp_rdy(i);
      dn[i] = (mn[i] > 0) && out_ready;
    end
    @(posedge clk);
    for (int i = 0; i < 2; i++) begin
      if (stat_clr)                                         mcnt[i] = 0;
      else if ((mn[i] > 0) && !out_ready && mcnt[i] < CNT_MAX) mcnt[i]++;
      if (dn[i]) begin
        $display("inst%0d: delivered %08h", i, mq[i][0]);
        mlast[i] = mq[i][0];
        mq[i][0] = mq[i][1];
        mn[i]--;
      end
      if (flush) begin
        mn[i] = 0;
        mlast[i] = '0;
      end else if (up[i]) begin
        mq[i][mn[i]] = in_data;
        mn[i]++;
      end
    end
    @(negedge clk);
  endtask

  task automatic set_in(input bit v, input logic [DW-1:0] d, input bit r, input bit f, input bit c);
    in_valid = v; in_data = d; out_ready = r; flush = f; stat_clr = c;
  endtask

  // Assert reset part-way through the low phase and check outputs immediately.
  task automatic async_reset(input string tag);
    #2 nrst = 1'b0;
    #1;
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("%s_out_valid[%0d]", tag, i), ov[i], 1'b0);
      chk($sformatf("%s_occupancy[%0d]", tag, i), oc[i], 2'd0);
      chk($sformatf("%s_stall_cnt[%0d]", tag, i), sc[i], '0);
      chk($sformatf("%s_out_data[%0d]", tag, i),  od[i], '0);
      chk($sformatf("%s_in_ready[%0d]", tag, i),  ir[i], 1'b1);
    end
    model_clear();
    $display("reset asserted (%s)", tag);
    @(posedge clk);
    @(negedge clk);
    nrst = 1'b1;
  endtask

  initial begin
    nrst = 1'b0;
    set_in(0, '0, 0, 0, 0);
    model_clear();
    repeat (3) @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("por_in_ready[%0d]", i), ir[i], 1'b1);
      chk($sformatf("por_out_valid[%0d]", i), ov[i], 1'b0);
      chk($sformatf("por_out_data[%0d]", i), od[i], '0);
    end
    nrst = 1'b1;
    cycle();

    // streaming at full rate
    for (int k = 1; k <= 10; k++) begin
      set_in(1, DW'(k), 1, 0, 0);
      cycle();
    end
    set_in(0, '0, 1, 0, 0); cycle(); cycle();

    // fill skid while blocked, then drain in order
    set_in(1, 32'hA, 0, 0, 0); cycle();
    set_in(1, 32'hB, 0, 0, 0); cycle();
    set_in(0, '0, 0, 0, 0);    cycle();
    chk("skid_full_occ", oc[0], 2'd2);
    chk("skid_full_rdy", ir[0], 1'b0);
    set_in(0, '0, 1, 0, 0);    cycle(); cycle(); cycle();

    // flush from a full skid with a competing upstream entry
    set_in(1, 32'hA, 0, 0, 0); cycle();
    set_in(1, 32'hB, 0, 0, 0); cycle();
    set_in(1, 32'hC, 0, 1, 0); cycle();
    chk("flush_occ", oc[0], 2'd0);
    chk("flush_data", od[0], '0);
    set_in(0, '0, 1, 0, 0);    cycle(); cycle(); cycle();

    // stall counter saturation and clear
    set_in(1, 32'hD, 0, 0, 0);
    repeat (20) cycle();
    chk("sat_cnt0", sc[0], 4'd15);
    chk("sat_cnt1", sc[1], 4'd15);
    set_in(1, 32'hD, 0, 0, 1); cycle();
    chk("clr_cnt0", sc[0], 4'd0);
    set_in(1, 32'hD, 0, 0, 0); cycle(); cycle(); cycle();

    // asynchronous reset while the skid instance is full
    chk("pre_reset_occ", oc[0], 2'd2);
    async_reset("rst_two");
    set_in(0, '0, 1, 0, 0); cycle();

    // randomized traffic with phased downstream back-pressure
    for (int n = 0; n < 1500; n++) begin
      int bias;
      bias = ((n / 150) % 3 == 0) ? 2 : (((n / 150) % 3 == 1) ? 6 : 9);
      set_in($urandom_range(0, 9) < 7, $urandom, $urandom_range(0, 9) < bias,
             $urandom_range(0, 99) < 3, $urandom_range(0, 99) < 2);
      if (n == 700) async_reset("rst_rand");
      cycle();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/elastic_ppreg.md
ELASTIC_PPREG -- requirements
Module: elastic_ppreg

Interface
REQ-001 Parameter DATA_W, default 128, payload width in bits (1..1024).
REQ-002 Parameter SKID, default 1, 1 = two-entry skid mode with registered in_ready, 0 = single-entry stall mode with combinational in_ready.
REQ-003 Parameter CNT_W, default 16, width of stall-cycle counter.
REQ-004 clk  input  1  single clock, all state updates on rising edge.
REQ-005 nrst  input  1  asynchronous active-low reset.
REQ-006 flush  input  1  synchronous kill of all held and incoming entries.
REQ-007 in_valid  input  1  upstream entry present.
REQ-008 in_ready  output  1  block accepts upstream entry this cycle.
REQ-009 in_data  input  DATA_W  upstream payload.
REQ-010 out_valid  output  1  entry presented downstream.
REQ-011 out_ready  input  1  downstream accepts entry this cycle.
REQ-012 out_data  output  DATA_W  downstream payload, driven directly from main register.
REQ-013 occupancy  output  2  entries held: 0, 1 or 2.
REQ-014 stat_clr  input  1  synchronous clear of stall counter.
REQ-015 stall_cnt  output  CNT_W  cycles with out_valid=1 and out_ready=0.

Function
REQ-016 Upstream transfer on in_valid&in_ready; downstream transfer on out_valid&out_ready; one-cycle latency in to out when empty.
REQ-017 States EMPTY (occ 0), ONE (main full), TWO (main+skid full; SKID=1 only); out_valid=1 in ONE and TWO.
REQ-018 EMPTY: upstream transfer -> ONE, main<=in_data.
REQ-019 ONE: down+up transfer -> ONE, main<=in_data; down only -> EMPTY; up only (SKID=1) -> TWO, skid<=in_data.
REQ-020 TWO: down transfer -> ONE, main<=skid; no upstream transfer possible.
REQ-021 SKID=1: in_ready=1 iff state!=TWO, from flops only, no combinational path from out_ready.
REQ-022 SKID=0: in_ready=out_ready|(state==EMPTY); state TWO unreachable; skid register not instantiated.
REQ-023 Entries leave in arrival order; no entry duplicated or dropped except by flush.
REQ-024 flush: next state EMPTY, main and skid registers zeroed, concurrent upstream transfer discarded; a downstream transfer in the flush cycle completes normally.
REQ-025 flush takes priority over every accept/advance rule.
REQ-026 out_data retains last value after normal drain to EMPTY; zero after reset or flush.
REQ-027 stall_cnt increments by 1 on cycles with out_valid&~out_ready, saturates at 2^CNT_W-1, no wrap.
REQ-028 stat_clr zeroes stall_cnt next cycle, priority over increment; flush does not affect stall_cnt.

Reset
REQ-029 nrst low asynchronously forces: state EMPTY, out_valid 0, out_data 0, skid 0, occupancy 0, stall_cnt 0.
REQ-030 in_ready reads 1 during and after reset (both modes, state EMPTY).
REQ-031 Reset mid-transfer discards all held entries; no transfer recorded in assertion cycle.

Structure
REQ-032 Package pipe_pkg holds occupancy enum typedef (OCC_EMPTY=0, OCC_ONE=1, OCC_TWO=2) and stall counter default width constant.
REQ-033 One sub-module sat_cnt (parametrised width, inc, clr, async active-low reset) implements stall_cnt.

Verification
REQ-034 SKID=1, in_valid=1 with data 1,2,3..., out_ready=1 continuously -> out_data 1,2,3... one per cycle from cycle 1, occupancy stays 1.
REQ-035 SKID=1, ONE holding 0xA, out_ready=0, in_valid data 0xB -> occupancy 2, in_ready 0 next cycle; out_ready=1 -> 0xA then 0xB delivered, in_ready 1 after 0xA leaves.
REQ-036 SKID=1, TWO state, flush=1 with out_ready=0 and in_valid=1 -> next cycle occupancy 0, out_valid 0, out_data 0, no later delivery of any of the three entries.
REQ-037 SKID=0, out_ready=0 with ONE held -> in_ready 0 same cycle; out_ready=1 with in_valid -> in_ready 1 same cycle, single-cycle pass.
REQ-038 CNT_W=4, out_valid=1, out_ready=0 for 20 cycles -> stall_cnt 15 held; stat_clr 1 cycle -> 0, then resumes counting.
REQ-039 nrst asserted asynchronously mid-cycle in TWO -> out_valid 0, occupancy 0, stall_cnt 0 immediately; in_ready 1.
